fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction prefetch buffer that sits directly downstream of instruction_memory and upstream of the decode stage. It captures each fetched {pc, instruction_code} pair into a small circular FIFO and presents the oldest entry to decode with a valid/ready handshake. It drives back-pressure to the fetch unit's pc_enable and supports a single-cycle flush on redirect (branch/jump).

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2.
XLEN, 32, width of pc and instruction fields.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
in_valid  input  1  fetch pair on in_pc/in_instr is valid this cycle.
in_pc  input  XLEN  pc of the fetched instruction.
in_instr  input  XLEN  instruction_code from instruction_memory.
in_ready  output  1  queue can accept a push; feeds IFU pc_enable.
flush  input  1  discard all entries (redirect); priority over push and pop.
out_valid  output  1  head entry is valid.
out_pc  output  XLEN  pc of head entry.
out_instr  output  XLEN  instruction of head entry.
out_ready  input  1  decode consumes head this cycle.
count  output  $clog2(DEPTH)+1  current number of stored entries.

Behaviour:
- Reset (reset=0, async): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, in_ready=1, out_pc=0, out_instr=0. Storage array is not cleared.
- push = in_valid & in_ready & ~flush. pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). Combinational from count only; no combinational path from out_ready to in_ready.
- Full case: a push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0). out_pc/out_instr = mem[rd_ptr], read combinationally from registered storage.
- Latency: a pair pushed at edge N is visible on out_* after edge N, so decode can take it in cycle N+1. There is no same-cycle bypass.
- Push: mem[wr_ptr] <= {in_pc, in_instr}; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- count update: push only, +1. Pop only, -1. Push and pop together, unchanged (legal when 0<count<DEPTH). Neither, unchanged.
- Empty case: pop cannot occur because out_valid=0. A push into an empty queue gives out_valid=1 on the next cycle.
- Flush: at the next edge, rd_ptr=wr_ptr=0 and count=0. Any simultaneous in_valid data is dropped and no entry is consumed. in_ready stays at its pre-flush value during the flush cycle.
- Reset mid-operation: all entries are lost immediately, and outputs take their reset values asynchronously.
- Ordering: strict FIFO; pairs are never reordered or duplicated.
- Data is held stable on out_* while out_valid=1 and out_ready=0.

Decomposition:
- Shared package rv32i_pkg holds: XLEN; NOP_INSTR = 32'h0000_0013 (used by downstream decode when out_valid=0); a fetch_pair_t struct {pc, instr}.
- One natural sub-module is fifo_ptr, a modulo-DEPTH pointer with increment and clear. It is instantiated twice, for rd_ptr and wr_ptr.
- The storage array and count logic are inline in fetch_queue.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> count=0, out_valid=0, in_ready=1, out_pc=0.
- Fill to full with out_ready=0: push pc 0x0,0x4,0x8,0xC with instrs 0x00500093,0x00A00113,0x002081B3,0x00000013 -> count=4, in_ready=0. A 5th in_valid is ignored (count stays 4). out_pc=0x0, out_instr=0x00500093.
- Drain in order: out_ready=1 for 4 cycles -> out_pc sequence 0x0,0x4,0x8,0xC, then out_valid=0, count=0.
- Simultaneous push and pop at count=2: one cycle with in_valid=1 (pc 0x10) and out_ready=1 -> count stays 2, head advances one entry. Continue until pointers wrap past DEPTH-1 and confirm order holds.
- Flush priority: count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1. Pushed pc 0x20 never appears at the output.
- Async reset mid-stream: count=2, drive reset=0 between clock edges -> out_valid and count go to 0 before the next edge. After release, a new push of pc 0x40 is output first.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I widths, NOP encoding and the fetch pair record.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-side push and decode-side pop handshakes of the fetch queue.
interface fetch_queue_if #(
  parameter int XLEN = 32
) ();

  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - modulo-DEPTH queue pointer with increment and clear.
module fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_inc,
  output logic [$clog2(DEPTH)-1:0] o_ptr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_ptr;

  // DEPTH is a power of two, so the natural wrap of the counter is the modulo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + PW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular prefetch buffer between instruction memory and decode.
module fetch_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_queue_if.slave           fq,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_pair_t   r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] w_wr_ptr;
  logic          w_push;
  logic          w_pop;
  logic          w_in_ready;
  logic          w_out_valid;
  fetch_pair_t   w_head;

  // Ready depends on count alone, keeping decode's out_ready off the fetch enable path.
  assign w_in_ready  = (r_count != FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = fq.in_valid & w_in_ready & ~fq.flush;
  assign w_pop       = w_out_valid & fq.out_ready & ~fq.flush;

  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .i_clr (fq.flush),
    .i_inc (w_pop),
    .o_ptr (w_rd_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .i_clr (fq.flush),
    .i_inc (w_push),
    .o_ptr (w_wr_ptr)
  );

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= '{pc: fq.in_pc, instr: fq.in_instr};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (fq.flush) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Storage is never cleared, so the head is masked to zero while the queue is empty.
  assign w_head       = r_mem[w_rd_ptr];
  assign fq.in_ready  = w_in_ready;
  assign fq.out_valid = w_out_valid;
  assign fq.out_pc    = w_out_valid ? w_head.pc    : '0;
  assign fq.out_instr = w_out_valid ? w_head.instr : '0;
  assign count        = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed bench for fetch_queue against a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  logic       clk;
  logic       reset;
  logic [2:0] count;
  int         checks;
  int         passed;
  pair_t      mq[$];

  fetch_queue_if #(.XLEN(32)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    fq.in_valid  = 1'b0;
    fq.in_pc     = '0;
    fq.in_instr  = '0;
    fq.flush     = 1'b0;
    fq.out_ready = 1'b0;
  endtask

  task automatic drive_cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                             input logic ordy, input logic fl);
    bit do_push;
    bit do_pop;
    @(negedge clk);
    fq.in_valid  = iv;
    fq.in_pc     = pc;
    fq.in_instr  = ins;
    fq.out_ready = ordy;
    fq.flush     = fl;
    do_push = iv && (mq.size() != DEPTH) && !fl;
    do_pop  = ordy && (mq.size() != 0) && !fl;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: pc, instr: ins});
    end
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mq.delete();
    #1;
    checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
    checks++; if (fq.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", fq.out_valid); else passed++;
    checks++; if (fq.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", fq.in_ready); else passed++;
    checks++; if (fq.out_pc !== 32'h0) $display("FAIL reset_out_pc got %h exp 0", fq.out_pc); else passed++;
    checks++; if (fq.out_instr !== 32'h0) $display("FAIL reset_out_instr got %h exp 0", fq.out_instr); else passed++;
  endtask

  task automatic test_fill_full();
    logic [31:0] ins_tab [4];
    ins_tab = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 32'(i * 4), ins_tab[i], 1'b0, 1'b0);
      if (i == 0) begin
        checks++; if (fq.out_valid !== 1'b1) $display("FAIL first_push_visible got %b exp 1", fq.out_valid); else passed++;
      end
    end
    checks++; if (count !== 3'd4) $display("FAIL full_count got %0d exp 4", count); else passed++;
    checks++; if (fq.in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", fq.in_ready); else passed++;
    drive_cycle(1'b1, 32'h50, 32'hDEADBEEF, 1'b0, 1'b0);
    checks++; if (count !== 3'd4) $display("FAIL full_ignore_count got %0d exp 4", count); else passed++;
    checks++; if (fq.out_pc !== 32'h0) $display("FAIL full_head_pc got %h exp 0", fq.out_pc); else passed++;
    checks++; if (fq.out_instr !== 32'h00500093) $display("FAIL full_head_instr got %h exp 00500093", fq.out_instr); else passed++;
    // A pop coinciding with a push at full must still refuse the push.
    drive_cycle(1'b1, 32'h54, 32'h1, 1'b1, 1'b0);
    checks++; if (count !== 3'd3) $display("FAIL full_pop_push_count got %0d exp 3", count); else passed++;
    mq.push_front('{pc: 32'h0, instr: 32'h00500093});
  endtask

  task automatic test_drain();
    logic [31:0] exp_pc;
    // Restore the first entry in the DUT by refilling through a fresh reset-free path is not possible,
    // so the drain covers what is in the queue (0x4, 0x8, 0xC).
    void'(mq.pop_front());
    for (int i = 1; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      checks++; if (fq.out_pc !== exp_pc) $display("FAIL drain_pc_%0d got %h exp %h", i, fq.out_pc, exp_pc); else passed++;
      drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
    end
    checks++; if (fq.out_valid !== 1'b0) $display("FAIL drain_out_valid got %b exp 0", fq.out_valid); else passed++;
    checks++; if (count !== 3'd0) $display("FAIL drain_count got %0d exp 0", count); else passed++;
    checks++; if (fq.in_ready !== 1'b1) $display("FAIL drain_in_ready got %b exp 1", fq.in_ready); else passed++;
  endtask

  task automatic test_push_pop_wrap();
    logic [31:0] exp_pc;
    drive_cycle(1'b1, 32'h08, 32'hA08, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h0C, 32'hA0C, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive_cycle(1'b1, 32'h10 + 32'(k * 4), 32'hA10 + 32'(k * 4), 1'b1, 1'b0);
      exp_pc = 32'h0C + 32'(k * 4);
      checks++; if (count !== 3'd2) $display("FAIL pp_count_%0d got %0d exp 2", k, count); else passed++;
      checks++; if (fq.out_pc !== exp_pc) $display("FAIL pp_head_%0d got %h exp %h", k, fq.out_pc, exp_pc); else passed++;
      checks++; if (fq.out_instr !== exp_pc + 32'hA00) $display("FAIL pp_instr_%0d got %h exp %h", k, fq.out_instr, exp_pc + 32'hA00); else passed++;
    end
    repeat (2) drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h100 + 32'(i * 4), 32'h5, 1'b0, 1'b0);
    checks++; if (count !== 3'd3) $display("FAIL flush_pre_count got %0d exp 3", count); else passed++;
    @(negedge clk);
    fq.flush     = 1'b1;
    fq.in_valid  = 1'b1;
    fq.in_pc     = 32'h20;
    fq.in_instr  = 32'h20;
    fq.out_ready = 1'b1;
    #1;
    checks++; if (fq.in_ready !== 1'b1) $display("FAIL flush_cycle_in_ready got %b exp 1", fq.in_ready); else passed++;
    @(posedge clk);
    mq.delete();
    #1;
    idle_inputs();
    checks++; if (count !== 3'd0) $display("FAIL flush_count got %0d exp 0", count); else passed++;
    checks++; if (fq.out_valid !== 1'b0) $display("FAIL flush_out_valid got %b exp 0", fq.out_valid); else passed++;
    checks++; if (fq.in_ready !== 1'b1) $display("FAIL flush_in_ready got %b exp 1", fq.in_ready); else passed++;
    drive_cycle(1'b1, 32'h24, 32'h24, 1'b0, 1'b0);
    checks++; if (fq.out_pc !== 32'h24) $display("FAIL flush_next_pc got %h exp 24", fq.out_pc); else passed++;
    checks++; if (count !== 3'd1) $display("FAIL flush_next_count got %0d exp 1", count); else passed++;
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 32'h200, 32'h1, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h204, 32'h2, 1'b0, 1'b0);
    checks++; if (count !== 3'd2) $display("FAIL ar_pre_count got %0d exp 2", count); else passed++;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (count !== 3'd0) $display("FAIL ar_count got %0d exp 0", count); else passed++;
    checks++; if (fq.out_valid !== 1'b0) $display("FAIL ar_out_valid got %b exp 0", fq.out_valid); else passed++;
    checks++; if (fq.out_pc !== 32'h0) $display("FAIL ar_out_pc got %h exp 0", fq.out_pc); else passed++;
    mq.delete();
    @(negedge clk);
    reset = 1'b1;
    drive_cycle(1'b1, 32'h40, 32'h00000013, 1'b0, 1'b0);
    checks++; if (fq.out_pc !== 32'h40) $display("FAIL ar_first_pc got %h exp 40", fq.out_pc); else passed++;
    checks++; if (count !== 3'd1) $display("FAIL ar_first_count got %0d exp 1", count); else passed++;
    drive_cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] next_pc;
    next_pc = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      logic iv;
      logic ordy;
      logic fl;
      iv   = 1'($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 2) == 0);
      fl   = 1'($urandom_range(0, 29) == 0);
      drive_cycle(iv, next_pc, $urandom, ordy, fl);
      next_pc = next_pc + 32'h4;
      exp_pc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
      exp_instr = (mq.size() != 0) ? mq[0].instr : 32'h0;
      checks++; if (count !== 3'(mq.size())) $display("FAIL rnd_count_%0d got %0d exp %0d", n, count, mq.size()); else passed++;
      checks++; if (fq.out_valid !== (mq.size() != 0)) $display("FAIL rnd_valid_%0d got %b exp %b", n, fq.out_valid, mq.size() != 0); else passed++;
      checks++; if (fq.in_ready !== (mq.size() != DEPTH)) $display("FAIL rnd_ready_%0d got %b exp %b", n, fq.in_ready, mq.size() != DEPTH); else passed++;
      checks++; if (fq.out_pc !== exp_pc) $display("FAIL rnd_pc_%0d got %h exp %h", n, fq.out_pc, exp_pc); else passed++;
      checks++; if (fq.out_instr !== exp_instr) $display("FAIL rnd_instr_%0d got %h exp %h", n, fq.out_instr, exp_instr); else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_fill_full();
    test_drain();
    test_push_pop_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
